// File: rtl/perf_event_counters.sv
// Per-core performance event counter banks, each reached through its own
// single-cycle peripheral slave port with a registered response.
module perf_event_counters #(
    parameter int unsigned NB_CORES     = 8,
    parameter int unsigned NB_EVENTS    = 8,
    parameter int unsigned CNT_WIDTH    = 32,
    parameter int unsigned PER_ID_WIDTH = 5
) (
    input  logic                                    clk_i,
    input  logic                                    rst_ni,
    input  logic [NB_CORES-1:0][NB_EVENTS-1:0]      evt_i,
    input  logic [NB_CORES-1:0]                     req_i,
    input  logic [NB_CORES-1:0][31:0]               add_i,
    input  logic [NB_CORES-1:0]                     wen_i,
    input  logic [NB_CORES-1:0][31:0]               wdata_i,
    input  logic [NB_CORES-1:0][PER_ID_WIDTH-1:0]   id_i,
    output logic [NB_CORES-1:0]                     gnt_o,
    output logic [NB_CORES-1:0]                     r_valid_o,
    output logic [NB_CORES-1:0][31:0]               r_rdata_o,
    output logic [NB_CORES-1:0]                     r_opc_o,
    output logic [NB_CORES-1:0][PER_ID_WIDTH-1:0]   r_id_o,
    output logic [NB_CORES-1:0]                     ovf_irq_o
);

    localparam int unsigned IDX_W  = 6;
    localparam int unsigned DATA_W = 32;

    localparam logic [IDX_W-1:0] IDX_CTRL  = 6'd0;
    localparam logic [IDX_W-1:0] IDX_MASK  = 6'd1;
    localparam logic [IDX_W-1:0] IDX_OVF   = 6'd2;
    localparam logic [IDX_W-1:0] IDX_IRQEN = 6'd3;
    localparam logic [IDX_W-1:0] IDX_CNT0  = 6'd16;

    // The slave ports never stall.
    assign gnt_o = '1;

    for (genvar c = 0; c < NB_CORES; c++) begin : g_core
        logic [IDX_W-1:0]                     w_idx;
        logic                                 w_wr;
        logic                                 w_rd;
        logic                                 w_map;
        logic                                 w_clr;
        logic                                 r_en;
        logic                                 w_en_nxt;
        logic [NB_EVENTS-1:0]                 r_mask;
        logic [NB_EVENTS-1:0]                 w_mask_nxt;
        logic [NB_EVENTS-1:0]                 r_ovf;
        logic [NB_EVENTS-1:0]                 w_ovf_nxt;
        logic [NB_EVENTS-1:0]                 r_irqen;
        logic [NB_EVENTS-1:0]                 w_irqen_nxt;
        logic [NB_EVENTS-1:0]                 w_wrap;
        logic [NB_EVENTS-1:0][CNT_WIDTH-1:0]  r_cnt;
        logic [NB_EVENTS-1:0][CNT_WIDTH-1:0]  w_cnt_nxt;
        logic [DATA_W-1:0]                    w_rdata;
        logic [DATA_W-1:0]                    r_rsp_rdata;
        logic                                 r_rsp_valid;
        logic                                 r_rsp_opc;
        logic [PER_ID_WIDTH-1:0]              r_rsp_id;
        logic                                 r_irq;
        logic                                 w_unused;

        assign w_idx = add_i[c][7:2];
        assign w_wr  = req_i[c] & ~wen_i[c];
        assign w_rd  = req_i[c] & wen_i[c];
        assign w_map = (w_idx <= IDX_IRQEN) ||
                       ((w_idx >= IDX_CNT0) && (w_idx < (IDX_CNT0 + IDX_W'(NB_EVENTS))));
        assign w_clr = w_wr && (w_idx == IDX_CTRL) && wdata_i[c][2];

        // Only the word index and the low data bits are meaningful.
        assign w_unused = ^{add_i[c], wdata_i[c]};

        // Counter update: clear beats a direct write, which beats an increment.
        always_comb begin
            w_cnt_nxt = r_cnt;
            w_wrap    = '0;
            for (int k = 0; k < NB_EVENTS; k++) begin
                if (w_clr) begin
                    w_cnt_nxt[k] = '0;
                end else if (w_wr && (w_idx == (IDX_CNT0 + IDX_W'(k)))) begin
                    w_cnt_nxt[k] = wdata_i[c][CNT_WIDTH-1:0];
                end else if (r_en && r_mask[k] && evt_i[c][k]) begin
                    w_cnt_nxt[k] = r_cnt[k] + CNT_WIDTH'(1);
                    w_wrap[k]    = &r_cnt[k];
                end
            end
        end

        // Control/config update; a fresh wrap always survives a same-cycle W1C.
        always_comb begin
            w_en_nxt    = r_en;
            w_mask_nxt  = r_mask;
            w_irqen_nxt = r_irqen;
            w_ovf_nxt   = r_ovf | w_wrap;
            if (w_wr) begin
                case (w_idx)
                    IDX_CTRL: begin
                        if (wdata_i[c][1]) begin
                            w_en_nxt = 1'b0;
                        end else if (wdata_i[c][0]) begin
                            w_en_nxt = 1'b1;
                        end
                    end
                    IDX_MASK:  w_mask_nxt  = wdata_i[c][NB_EVENTS-1:0];
                    IDX_OVF:   w_ovf_nxt   = (r_ovf & ~wdata_i[c][NB_EVENTS-1:0]) | w_wrap;
                    IDX_IRQEN: w_irqen_nxt = wdata_i[c][NB_EVENTS-1:0];
                    default:   ;
                endcase
            end
        end

        // Read mux reflects register state before this cycle's update.
        always_comb begin
            w_rdata = '0;
            case (w_idx)
                IDX_CTRL:  w_rdata = DATA_W'(r_en);
                IDX_MASK:  w_rdata = DATA_W'(r_mask);
                IDX_OVF:   w_rdata = DATA_W'(r_ovf);
                IDX_IRQEN: w_rdata = DATA_W'(r_irqen);
                default:   w_rdata = '0;
            endcase
            for (int k = 0; k < NB_EVENTS; k++) begin
                if (w_idx == (IDX_CNT0 + IDX_W'(k))) begin
                    w_rdata = DATA_W'(r_cnt[k]);
                end
            end
        end

        always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
                r_cnt   <= '0;
                r_en    <= 1'b0;
                r_mask  <= '0;
                r_ovf   <= '0;
                r_irqen <= '0;
                r_irq   <= 1'b0;
            end else begin
                r_cnt   <= w_cnt_nxt;
                r_en    <= w_en_nxt;
                r_mask  <= w_mask_nxt;
                r_ovf   <= w_ovf_nxt;
                r_irqen <= w_irqen_nxt;
                r_irq   <= |(r_ovf & r_irqen);
            end
        end

        // One response per request, one cycle later.
        always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
                r_rsp_valid <= 1'b0;
                r_rsp_opc   <= 1'b0;
                r_rsp_id    <= '0;
                r_rsp_rdata <= '0;
            end else begin
                r_rsp_valid <= req_i[c];
                r_rsp_opc   <= req_i[c] & ~w_map;
                r_rsp_id    <= req_i[c] ? id_i[c] : '0;
                r_rsp_rdata <= (w_rd && w_map) ? w_rdata : '0;
            end
        end

        assign r_valid_o[c] = r_rsp_valid;
        assign r_opc_o[c]   = r_rsp_opc;
        assign r_id_o[c]    = r_rsp_id;
        assign r_rdata_o[c] = r_rsp_rdata;
        assign ovf_irq_o[c] = r_irq;
    end

endmodule

// File: tb/tb_perf_event_counters.sv
// Directed bench for perf_event_counters; responses are checked against a
// queue of expectations pushed as each request is driven.
module tb_perf_event_counters;

    localparam int unsigned NC = 4;
    localparam int unsigned NE = 4;
    localparam int unsigned CW = 8;
    localparam int unsigned IW = 5;

    localparam logic [5:0] I_CTRL  = 6'd0;
    localparam logic [5:0] I_MASK  = 6'd1;
    localparam logic [5:0] I_OVF   = 6'd2;
    localparam logic [5:0] I_IRQEN = 6'd3;
    localparam logic [5:0] I_CNT0  = 6'd16;

    logic                      clk_i;
    logic                      rst_ni;
    logic [NC-1:0][NE-1:0]     evt_i;
    logic [NC-1:0]             req_i;
    logic [NC-1:0][31:0]       add_i;
    logic [NC-1:0]             wen_i;
    logic [NC-1:0][31:0]       wdata_i;
    logic [NC-1:0][IW-1:0]     id_i;
    logic [NC-1:0]             gnt_o;
    logic [NC-1:0]             r_valid_o;
    logic [NC-1:0][31:0]       r_rdata_o;
    logic [NC-1:0]             r_opc_o;
    logic [NC-1:0][IW-1:0]     r_id_o;
    logic [NC-1:0]             ovf_irq_o;

    typedef struct {
        int          core;
        logic [IW-1:0] id;
        logic [31:0] rdata;
        logic        opc;
    } exp_t;

    exp_t        sb[$];
    int          total = 0;
    int          bad   = 0;
    logic [IW-1:0] next_id = '0;
    logic [31:0] exp_all [NC];

    perf_event_counters #(
        .NB_CORES(NC), .NB_EVENTS(NE), .CNT_WIDTH(CW), .PER_ID_WIDTH(IW)
    ) dut (
        .clk_i(clk_i), .rst_ni(rst_ni), .evt_i(evt_i), .req_i(req_i),
        .add_i(add_i), .wen_i(wen_i), .wdata_i(wdata_i), .id_i(id_i),
        .gnt_o(gnt_o), .r_valid_o(r_valid_o), .r_rdata_o(r_rdata_o),
        .r_opc_o(r_opc_o), .r_id_o(r_id_o), .ovf_irq_o(ovf_irq_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // One request on core c; returns on the negedge where its response is visible.
    task automatic bus(input int c, input bit rd, input logic [5:0] idx,
                       input logic [31:0] wd, input logic [31:0] exp_rd, input bit exp_opc);
        req_i      = '0;
        req_i[c]   = 1'b1;
        wen_i[c]   = rd;
        add_i[c]   = {24'd0, idx, 2'b00};
        wdata_i[c] = wd;
        id_i[c]    = next_id;
        sb.push_back('{core: c, id: next_id, rdata: (rd ? exp_rd : 32'd0), opc: exp_opc});
        next_id    = next_id + IW'(1);
        @(negedge clk_i);
        req_i = '0;
    endtask

    // Response monitor: pops the oldest expectation for every valid response.
    always @(negedge clk_i) begin
        for (int c = 0; c < NC; c++) begin
            if (r_valid_o[c]) begin
                total++;
                assert (sb.size() != 0) else begin
                    bad++;
                    $error("FAIL unexpected_rsp core=%0d observed=valid expected=none", c);
                end
                if (sb.size() != 0) begin
                    exp_t e;
                    e = sb.pop_front();
                    chk("rsp_core", 32'(c), 32'(e.core));
                    chk("rsp_id", 32'(r_id_o[c]), 32'(e.id));
                    chk("rsp_opc", 32'(r_opc_o[c]), 32'(e.opc));
                    chk("rsp_rdata", r_rdata_o[c], e.rdata);
                end
            end
        end
    end

    initial begin
        rst_ni = 1'b0;
        evt_i = '0; req_i = '0; add_i = '0; wen_i = '0; wdata_i = '0; id_i = '0;
        repeat (2) @(negedge clk_i);
        chk("rst_gnt", 32'(gnt_o), 32'hF);
        chk("rst_valid", 32'(r_valid_o), 32'h0);
        chk("rst_rdata", 32'(|r_rdata_o), 32'h0);
        chk("rst_opc_id", 32'({r_opc_o, r_id_o}), 32'h0);
        chk("rst_irq", 32'(ovf_irq_o), 32'h0);
        rst_ni = 1'b1;
        @(negedge clk_i);
        bus(0, 1, I_CTRL, 0, 0, 0);
        bus(0, 1, I_MASK, 0, 0, 0);

        // Count: only core0 event 0 is enabled, every event line is active.
        bus(0, 0, I_MASK, 32'h1, 0, 0);
        bus(0, 0, I_CTRL, 32'h1, 0, 0);
        evt_i = '1;
        repeat (10) @(negedge clk_i);
        evt_i = '0;
        bus(0, 1, I_CNT0, 0, 32'd10, 0);
        bus(0, 1, I_CNT0 + 6'd1, 0, 32'd0, 0);
        bus(1, 1, I_CNT0, 0, 32'd0, 0);
        bus(3, 1, I_CNT0, 0, 32'd0, 0);

        // Bus: simultaneous reads on all cores, unmapped accesses.
        bus(2, 0, I_CNT0, 32'h5A, 0, 0);
        exp_all[0] = 32'd10; exp_all[1] = 32'd0; exp_all[2] = 32'h5A; exp_all[3] = 32'd0;
        req_i = '1;
        for (int c = 0; c < NC; c++) begin
            wen_i[c] = 1'b1;
            add_i[c] = {24'd0, I_CNT0, 2'b00};
            id_i[c]  = IW'(20 + c);
            sb.push_back('{core: c, id: IW'(20 + c), rdata: exp_all[c], opc: 1'b0});
        end
        @(negedge clk_i);
        req_i = '0;
        bus(1, 1, 6'd40, 0, 0, 1);
        bus(0, 0, 6'd20, 32'hFF, 0, 1);
        bus(0, 1, I_CNT0 + 6'd3, 0, 32'd0, 0);
        bus(0, 1, I_CNT0, 0, 32'd10, 0);

        // Stop while events continue; start+stop together leaves en cleared.
        evt_i[0][0] = 1'b1;
        bus(0, 0, I_CTRL, 32'h2, 0, 0);
        repeat (5) @(negedge clk_i);
        bus(0, 1, I_CNT0, 0, 32'd11, 0);
        bus(0, 1, I_CTRL, 0, 32'd0, 0);
        bus(0, 0, I_CTRL, 32'h3, 0, 0);
        bus(0, 1, I_CTRL, 0, 32'd0, 0);
        bus(0, 1, I_CNT0, 0, 32'd11, 0);
        evt_i = '0;

        // Priority: direct write beats increment, clear+start beats both.
        bus(0, 0, I_MASK, 32'hF, 0, 0);
        bus(0, 0, I_CTRL, 32'h1, 0, 0);
        evt_i[0] = 4'b0011;
        bus(0, 0, I_CNT0, 32'h33, 0, 0);
        bus(0, 1, I_CNT0, 0, 32'h33, 0);
        bus(0, 0, I_CTRL, 32'h5, 0, 0);
        @(negedge clk_i);
        evt_i = '0;
        bus(0, 1, I_CNT0, 0, 32'd1, 0);
        bus(0, 1, I_CNT0 + 6'd1, 0, 32'd1, 0);
        bus(0, 1, I_CNT0 + 6'd2, 0, 32'd0, 0);
        bus(0, 1, I_CTRL, 0, 32'd1, 0);
        bus(0, 0, I_CTRL, 32'h2, 0, 0);

        // Wrap on core1 with interrupt, then W1C.
        bus(1, 0, I_MASK, 32'h1, 0, 0);
        bus(1, 0, I_IRQEN, 32'h1, 0, 0);
        bus(1, 0, I_CNT0, 32'hFE, 0, 0);
        bus(1, 0, I_CTRL, 32'h1, 0, 0);
        evt_i[1][0] = 1'b1;
        repeat (2) @(negedge clk_i);
        chk("irq_lag", 32'(ovf_irq_o), 32'h0);
        @(negedge clk_i);
        evt_i = '0;
        chk("irq_set", 32'(ovf_irq_o), 32'h2);
        bus(1, 1, I_CNT0, 0, 32'h01, 0);
        bus(1, 1, I_OVF, 0, 32'h1, 0);
        bus(1, 0, I_OVF, 32'h1, 0, 0);
        chk("irq_hold", 32'(ovf_irq_o[1]), 32'h1);
        @(negedge clk_i);
        chk("irq_drop", 32'(ovf_irq_o[1]), 32'h0);
        bus(1, 1, I_OVF, 0, 32'h0, 0);
        bus(1, 1, I_IRQEN, 0, 32'h1, 0);

        // A new wrap in the same cycle as W1C keeps OVF set; clear keeps OVF.
        bus(1, 0, I_CNT0, 32'hFF, 0, 0);
        evt_i[1][0] = 1'b1;
        bus(1, 0, I_OVF, 32'h1, 0, 0);
        evt_i = '0;
        bus(1, 1, I_OVF, 0, 32'h1, 0);
        bus(1, 0, I_CTRL, 32'h4, 0, 0);
        bus(1, 1, I_CNT0, 0, 32'h0, 0);
        bus(1, 1, I_OVF, 0, 32'h1, 0);

        // Reset mid-count with a read presented: no response, state cleared.
        bus(0, 0, I_CTRL, 32'h1, 0, 0);
        evt_i = '1;
        repeat (3) @(negedge clk_i);
        req_i[0] = 1'b1; wen_i[0] = 1'b1; add_i[0] = {24'd0, I_CNT0, 2'b00};
        rst_ni = 1'b0;
        @(negedge clk_i);
        req_i = '0;
        chk("rstmid_valid", 32'(r_valid_o), 32'h0);
        chk("rstmid_irq", 32'(ovf_irq_o), 32'h0);
        chk("rstmid_gnt", 32'(gnt_o), 32'hF);
        rst_ni = 1'b1;
        repeat (3) @(negedge clk_i);
        bus(0, 1, I_CNT0, 0, 32'd0, 0);
        bus(0, 1, I_CTRL, 0, 32'd0, 0);
        bus(0, 1, I_MASK, 0, 32'd0, 0);
        bus(1, 1, I_OVF, 0, 32'd0, 0);
        bus(1, 1, I_IRQEN, 0, 32'd0, 0);
        bus(1, 1, I_CNT0, 0, 32'd0, 0);
        evt_i = '0;
        repeat (2) @(negedge clk_i);
        chk("sb_drained", 32'(sb.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/perf_event_counters.md
PERF_EVENT_COUNTERS -- requirements
Module: perf_event_counters

Interface
REQ-001 Parameter NB_CORES, default 8: number of cores; each core has one peripheral slave port and one private counter bank.
REQ-002 Parameter NB_EVENTS, default 8, legal range 1..16: event inputs and counters per core.
REQ-003 Parameter CNT_WIDTH, default 32, legal range 8..32: width of each counter.
REQ-004 Parameter PER_ID_WIDTH, default 5: width of the request/response transaction ID.
REQ-005 clk_i  in  1  clock; all state updates on the rising edge.
REQ-006 rst_ni  in  1  asynchronous, active-low reset.
REQ-007 evt_i  in  [NB_CORES][NB_EVENTS]  single-cycle event pulses; a high bit means one occurrence in that cycle.
REQ-008 req_i  in  [NB_CORES]  request valid, per port.
REQ-009 add_i  in  [NB_CORES][32]  byte address; only bits [7:2] are decoded.
REQ-010 wen_i  in  [NB_CORES]  1 = read, 0 = write.
REQ-011 wdata_i  in  [NB_CORES][32]  write data.
REQ-012 id_i  in  [NB_CORES][PER_ID_WIDTH]  request ID.
REQ-013 gnt_o  out  [NB_CORES]  grant; tied to 1.
REQ-014 r_valid_o  out  [NB_CORES]  response valid.
REQ-015 r_rdata_o  out  [NB_CORES][32]  read data.
REQ-016 r_opc_o  out  [NB_CORES]  1 = error response (unmapped address).
REQ-017 r_id_o  out  [NB_CORES][PER_ID_WIDTH]  response ID.
REQ-018 ovf_irq_o  out  [NB_CORES]  level-high while any overflow bit of that core is set and enabled by its IRQ enable.

Function
REQ-019 Port c SHALL access only bank c; banks are fully independent.
REQ-020 The word index add_i[7:2] SHALL map the bank registers as follows:
- 0 CTRL: write bit0 = start, bit1 = stop, bit2 = clear; read bit0 = en, other bits 0.
- 1 MASK: bits [NB_EVENTS-1:0] event enables, read/write.
- 2 OVF: sticky overflow bits, write-1-to-clear.
- 3 IRQEN: per-event overflow interrupt enables, read/write.
- 16+k: counter k, for k < NB_EVENTS; read/write.
REQ-021 Every request SHALL produce exactly one response 1 cycle later, r_valid_o = 1, with r_id_o equal to the registered id_i.
REQ-022 An unmapped address SHALL return r_opc_o = 1 and r_rdata_o = 0, with no state change; a mapped address SHALL return r_opc_o = 0.
REQ-023 A write response SHALL return r_rdata_o = 0.
REQ-024 Read data SHALL be the register value before any same-cycle update; counters are zero-extended to 32 bits.
REQ-025 Counter k of core c SHALL increment by 1 in a cycle where en = 1, MASK[k] = 1 and evt_i[c][k] = 1.
REQ-026 Counters SHALL wrap from 2^CNT_WIDTH-1 to 0; the wrapping increment SHALL set OVF[k].
REQ-027 Priority per counter, highest first:
- CTRL clear (all counters to 0; OVF unaffected);
- direct counter write (wdata_i[CNT_WIDTH-1:0]);
- increment.
REQ-028 CTRL write behaviour:
- start sets en;
- stop clears en;
- start and stop both set: stop wins;
- clear together with start: clear the counters and set en, with no increment counted in that cycle.
REQ-029 A write-1-to-clear on OVF bit k in the same cycle as a new overflow on counter k SHALL leave OVF[k] = 1.
REQ-030 ovf_irq_o[c] SHALL equal OR(OVF & IRQEN) of its bank, registered; it follows an OVF update by 1 cycle.
REQ-031 An event seen while en = 0 or MASK[k] = 0 SHALL be dropped, not deferred.

Reset
REQ-032 While rst_ni = 0, all of the following SHALL be 0:
- counters, en, MASK, OVF, IRQEN;
- r_valid_o, r_rdata_o, r_opc_o, r_id_o, ovf_irq_o.
REQ-033 gnt_o SHALL remain 1 during reset.
REQ-034 Reset asserted mid-count SHALL zero all state immediately; after release, counting SHALL resume only after a new MASK write and start.
REQ-035 A request in flight at reset assertion SHALL produce no response.

Verification
REQ-036 Count: core0 writes MASK = 0x1 then CTRL = 0x1; drive evt_i[0][0] high for 10 cycles -> counter 0 reads 10; other banks read 0.
REQ-037 Wrap: CNT_WIDTH = 8, preload counter 0 = 0xFE, IRQEN = 1, 3 events -> counter reads 0x01, OVF = 0x1, ovf_irq_o[0] = 1; then write OVF = 0x1 -> OVF = 0 and ovf_irq_o[0] drops 1 cycle later.
REQ-038 Priority: in one cycle apply CTRL = 0x5 with evt active and a counter write of 0x33 -> all counters 0 and en = 1; the next cycle's event gives 1.
REQ-039 Bus: all NB_CORES ports read counter 16 simultaneously with distinct IDs -> each gets its own bank value and matching r_id_o 1 cycle later; a read of index 40 -> r_opc_o = 1, r_rdata_o = 0.
REQ-040 Stop: stop while events continue -> the value freezes; start + stop in the same write -> en = 0.
REQ-041 Reset: assert rst_ni during counting with a read outstanding -> no r_valid_o; all reads after release return 0.
